// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: state encoding and default widths for the interval timer
package interval_timer_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN = 1'b1;
    localparam int DEF_COUNTER_WIDTH = 32;
    localparam int DEF_PRESCALE_WIDTH = 8;
    localparam int DEF_MISSED_WIDTH = 8;
endpackage

// File: rtl/interval_timer_ctrl_tick_prescaler.sv
// tick_prescaler: emits a one-cycle tick every (prescale_reg+1) enabled cycles
module tick_prescaler
    import interval_timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale_reg,
    output logic                      tick
);
    logic [PRESCALE_WIDTH-1:0] pcnt;
    assign tick = enable && pcnt == prescale_reg;
    always_ff @(posedge clk)
        if (rst || clear || !enable || tick) pcnt <= '0;
        else pcnt <= pcnt + 1'b1;
endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: one-shot/periodic interval timer with irq handshake and missed-expiry count
module interval_timer_ctrl
    import interval_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH  = DEF_COUNTER_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH,
    parameter int MISSED_WIDTH   = DEF_MISSED_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_load,
    input  logic [COUNTER_WIDTH-1:0]  cfg_period,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_periodic,
    input  logic                      start,
    input  logic                      stop,
    output logic                      irq_valid,
    input  logic                      irq_ready,
    output logic                      busy,
    output logic [COUNTER_WIDTH-1:0]  cnt,
    output logic [MISSED_WIDTH-1:0]   missed
);
    logic                      state, state_nxt, run, go, tick, expire;
    logic [COUNTER_WIDTH-1:0]  period_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_reg;
    logic                      periodic_reg;
    tick_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_presc (
        .clk(clk),
        .rst(rst),
        .clear(stop),
        .enable(run),
        .prescale_reg(prescale_reg),
        .tick(tick)
    );
    assign go = !run && start && !stop && period_reg != '0;
    assign expire = run && tick && cnt == period_reg - 1'b1;
    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_nxt;
    always_comb
        state_nxt = run ? ((stop || (expire && !periodic_reg)) ? ST_IDLE : ST_RUN)
                        : (go ? ST_RUN : ST_IDLE);
    always_comb begin
        run = state == ST_RUN;
        busy = run;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            period_reg <= '0;
            prescale_reg <= '0;
            periodic_reg <= 1'b0;
        end else if (!run && cfg_load) begin
            period_reg <= cfg_period;
            prescale_reg <= cfg_prescale;
            periodic_reg <= cfg_periodic;
        end
    end
    always_ff @(posedge clk)
        if (rst || go || expire) cnt <= '0;
        else if (tick && !stop) cnt <= cnt + 1'b1;
    always_ff @(posedge clk)
        if (rst) irq_valid <= 1'b0;
        else if (expire) irq_valid <= 1'b1;
        else if (irq_ready) irq_valid <= 1'b0;
    always_ff @(posedge clk)
        if (rst || (!run && cfg_load)) missed <= '0;
        else if (expire && irq_valid && !irq_ready && missed != '1) missed <= missed + 1'b1;
endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: vector table, directed corner cases and random run against a cycle-count model
module tb_interval_timer_ctrl;
    localparam int CW = 32;
    localparam int PW = 8;
    localparam int MW = 3;
    localparam longint MMAX = (64'd1 << MW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1, cfg_load = 1'b0, cfg_periodic = 1'b0, start = 1'b0, stop = 1'b0, irq_ready = 1'b0;
    logic [CW-1:0] cfg_period = '0;
    logic [PW-1:0] cfg_prescale = '0;
    logic irq_valid, busy;
    logic [CW-1:0] cnt;
    logic [MW-1:0] missed;
    int checks = 0, errors = 0;
    bit m_run, m_irq, m_pd;
    longint m_cnt, m_missed, m_per, m_pre, m_t;
    typedef struct {
        bit rst, ld;
        int per, pre;
        bit pd, st, sp, rdy;
        bit e_irq, e_busy;
        int e_cnt, e_missed;
    } vec_t;
    vec_t tbl[19];
    interval_timer_ctrl #(.COUNTER_WIDTH(CW), .PRESCALE_WIDTH(PW), .MISSED_WIDTH(MW)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_load(cfg_load),
        .cfg_period(cfg_period),
        .cfg_prescale(cfg_prescale),
        .cfg_periodic(cfg_periodic),
        .start(start),
        .stop(stop),
        .irq_valid(irq_valid),
        .irq_ready(irq_ready),
        .busy(busy),
        .cnt(cnt),
        .missed(missed)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // Expiries fall on every multiple of period*(prescale+1) cycles since the start edge.
    task automatic model_step();
        bit exp, go;
        if (rst) begin
            m_run = 0; m_irq = 0; m_pd = 0;
            m_cnt = 0; m_missed = 0; m_per = 0; m_pre = 0; m_t = 0;
            return;
        end
        exp = m_run && ((m_t + 1) % (m_per * (m_pre + 1)) == 0);
        if (exp && m_irq && !irq_ready && m_missed < MMAX) m_missed++;
        m_irq = exp || (m_irq && !irq_ready);
        if (m_run) begin
            m_t++;
            if (stop || (exp && !m_pd)) begin
                m_run = 0;
                if (exp) m_cnt = 0;
            end else m_cnt = (m_t / (m_pre + 1)) % m_per;
        end else begin
            go = start && !stop && m_per != 0;
            if (cfg_load) begin
                m_per = longint'(cfg_period); m_pre = longint'(cfg_prescale);
                m_pd = cfg_periodic; m_missed = 0;
            end
            if (go) begin
                m_run = 1; m_t = 0; m_cnt = 0;
            end
        end
    endtask
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model_irq", irq_valid, m_irq);
        chk("model_busy", busy, m_run);
        chk("model_cnt", cnt, m_cnt);
        chk("model_missed", missed, m_missed);
    endtask
    task automatic cyc(input bit r, ld, input int per, pre, input bit pd, st, sp, rdy);
        rst = r; cfg_load = ld; cfg_period = CW'(per); cfg_prescale = PW'(pre);
        cfg_periodic = pd; start = st; stop = sp; irq_ready = rdy;
        step();
    endtask
    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask
    initial begin
        tbl[0]  = '{1,0,0,0,0,0,0,0, 0,0,0,0};
        tbl[1]  = '{1,0,0,0,0,0,0,0, 0,0,0,0};
        tbl[2]  = '{0,0,0,0,0,1,0,0, 0,0,0,0};
        tbl[3]  = '{0,1,4,0,0,0,0,0, 0,0,0,0};
        tbl[4]  = '{0,0,0,0,0,1,0,0, 0,1,0,0};
        tbl[5]  = '{0,0,0,0,0,0,0,0, 0,1,1,0};
        tbl[6]  = '{0,0,0,0,0,0,0,0, 0,1,2,0};
        tbl[7]  = '{0,0,0,0,0,0,0,0, 0,1,3,0};
        tbl[8]  = '{0,0,0,0,0,0,0,0, 1,0,0,0};
        tbl[9]  = '{0,0,0,0,0,0,0,0, 1,0,0,0};
        tbl[10] = '{0,0,0,0,0,0,0,1, 0,0,0,0};
        tbl[11] = '{0,0,0,0,0,1,0,0, 0,1,0,0};
        tbl[12] = '{0,0,0,0,0,0,0,0, 0,1,1,0};
        tbl[13] = '{0,0,0,0,0,0,0,0, 0,1,2,0};
        tbl[14] = '{0,0,0,0,0,0,0,0, 0,1,3,0};
        tbl[15] = '{0,0,0,0,0,0,1,0, 1,0,0,0};
        tbl[16] = '{0,0,0,0,0,1,1,0, 1,0,0,0};
        tbl[17] = '{0,0,0,0,0,0,0,1, 0,0,0,0};
        tbl[18] = '{0,0,0,0,0,0,1,1, 0,0,0,0};
        for (int i = 0; i < 19; i++) begin
            cyc(tbl[i].rst, tbl[i].ld, tbl[i].per, tbl[i].pre, tbl[i].pd, tbl[i].st, tbl[i].sp, tbl[i].rdy);
            chk($sformatf("tbl%0d_irq", i), irq_valid, tbl[i].e_irq);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_missed", i), missed, tbl[i].e_missed);
        end
        cyc(0, 1, 3, 1, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 1; i <= 18; i++) begin
            idle(1, 1);
            chk($sformatf("per_cnt_e%0d", i), cnt, (i / 2) % 3);
            chk($sformatf("per_irq_e%0d", i), irq_valid, i % 6 == 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("per_stop_busy", busy, 0);
        cyc(0, 1, 2, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle(10, 0);
        chk("miss_irq_e10", irq_valid, 1);
        chk("miss_cnt_e10", missed, 4);
        cyc(0, 1, 7, 0, 1, 0, 1, 0);
        chk("miss_stop_busy", busy, 0);
        chk("miss_run_load_kept", missed, 4);
        idle(1, 1);
        chk("miss_ack_irq", irq_valid, 0);
        chk("miss_ack_missed", missed, 4);
        cyc(0, 1, 10, 0, 1, 0, 0, 0);
        chk("miss_idle_load_clr", missed, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle(5, 0);
        chk("stop_cnt5_pre", cnt, 5);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("stop_busy", busy, 0);
        chk("stop_cnt_hold", cnt, 5);
        chk("stop_no_irq", irq_valid, 0);
        idle(2, 0);
        chk("stop_cnt_hold2", cnt, 5);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        idle(8, 0);
        chk("runload_irq_e9", irq_valid, 0);
        chk("runload_cnt_e9", cnt, 9);
        idle(1, 0);
        chk("runload_irq_e10", irq_valid, 1);
        chk("runload_cnt_e10", cnt, 0);
        chk("runload_busy_e10", busy, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle(8, 0);
        chk("sat_e8", missed, 7);
        idle(1, 0);
        chk("sat_e9", missed, 7);
        chk("sat_irq", irq_valid, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_irq", irq_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_missed", missed, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_start_p0_busy", busy, 0);
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom),
                $urandom_range(0, 5) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 2) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
